// File: rtl/bcd_to_bin_converter_if.sv
// Request/response bundle for the BCD-to-binary converter: start/bcd_in in, status and result out.
interface bcd_to_bin_converter_if #(
  parameter int BIN_WIDTH  = 20,
  parameter int NUM_DIGITS = 6
);
  logic                    start;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    busy;
  logic                    done;
  logic [BIN_WIDTH-1:0]    bin_out;
  logic                    error;

  modport master (output start, bcd_in, input busy, done, bin_out, error);
  modport slave  (input start, bcd_in, output busy, done, bin_out, error);
endinterface

// File: rtl/bcd_to_bin_converter.sv
// Sequential BCD-to-binary converter using reverse double dabble, one bit per cycle.
// Invalid digits short-circuit straight to a done pulse with error set.
module bcd_to_bin_converter #(
  parameter int BIN_WIDTH  = 20,
  parameter int NUM_DIGITS = 6
) (
  input logic                  Clock,
  input logic                  Reset_n,
  bcd_to_bin_converter_if.slave bus
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_e;

  state_e               state_q, state_d;
  logic [SR_W-1:0]      sr_q, sr_d, sr_step;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic                 digits_ok;

  always_comb begin
    digits_ok = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (bus.bcd_in[4*k +: 4] > 4'd9) digits_ok = 1'b0;
  end

  // One iteration: shift the BCD:binary pair right, then pull any digit >= 8 back by 3.
  always_comb begin
    sr_step = sr_q >> 1;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (sr_step[BIN_WIDTH+4*k +: 4] >= 4'd8)
        sr_step[BIN_WIDTH+4*k +: 4] = sr_step[BIN_WIDTH+4*k +: 4] - 4'd3;
  end

  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = digits_ok ? CONVERT : DONE;
      CONVERT: if (cnt_q == LAST_ITER) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    bin_d  = bin_q;
    err_d  = err_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        if (digits_ok) begin
          sr_d   = {bus.bcd_in, {BIN_WIDTH{1'b0}}};
          cnt_d  = '0;
          busy_d = 1'b1;
        end else begin
          bin_d  = '0;
          err_d  = 1'b1;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      CONVERT: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          bin_d  = sr_step[BIN_WIDTH-1:0];
          err_d  = 1'b0;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bin_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bin_q  <= bin_d;
      err_q  <= err_d;
    end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bin_out = bin_q;
  assign bus.error   = err_q;
endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Randomized + directed bench for bcd_to_bin_converter against a decimal-arithmetic reference.
module tb_bcd_to_bin_converter;
  logic Clock, Reset_n;
  int   checks = 0;
  int   errors = 0;

  bcd_to_bin_converter_if bus ();

  bcd_to_bin_converter #(.BIN_WIDTH(20), .NUM_DIGITS(6)) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reading of the digits; any digit above 9 flags an error with zero result.
  function automatic void ref_model(input logic [23:0] b, output logic [19:0] v, output logic err);
    int acc, scale, d;
    acc = 0; scale = 1; err = 1'b0;
    for (int k = 0; k < 6; k++) begin
      d = int'((b >> (4*k)) & 24'hF);
      if (d > 9) err = 1'b1;
      acc += d * scale;
      scale *= 10;
    end
    v = err ? 20'd0 : 20'(acc);
  endfunction

  task automatic run_conv(input logic [23:0] v);
    logic [19:0] ev, prev_bin;
    logic        e, prev_err;
    int          n;
    bit          seen;
    ref_model(v, ev, e);
    prev_bin = bus.bin_out;
    prev_err = bus.error;
    bus.bcd_in = v;
    bus.start  = 1'b1;
    @(posedge Clock); #1;
    bus.start  = 1'b0;
    bus.bcd_in = 24'($urandom);
    if (e) begin
      chk("inv_done", 32'(bus.done), 1);
      chk("inv_err",  32'(bus.error), 1);
      chk("inv_bin",  32'(bus.bin_out), 0);
      chk("inv_busy", 32'(bus.busy), 0);
    end else begin
      chk("busy_e0", 32'(bus.busy), 1);
      chk("done_e0", 32'(bus.done), 0);
      n = 0; seen = 0;
      while (n < 40 && !seen) begin
        @(posedge Clock); #1;
        n++;
        if (bus.done) seen = 1;
        else begin
          chk("busy_hold", 32'(bus.busy), 1);
          chk("bin_hold", 32'(bus.bin_out), 32'(prev_bin));
          chk("err_hold", 32'(bus.error), 32'(prev_err));
        end
      end
      chk("latency", n, 20);
      chk("bin", 32'(bus.bin_out), 32'(ev));
      chk("err", 32'(bus.error), 0);
      chk("busy_done", 32'(bus.busy), 0);
    end
    @(posedge Clock); #1;
    chk("done_1cyc", 32'(bus.done), 0);
    chk("bin_after", 32'(bus.bin_out), 32'(ev));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] v;
    logic [3:0]  d;
    logic [19:0] cap;
    int          pulses, last, idx;

    Reset_n = 1'b0;
    bus.start = 1'b0;
    bus.bcd_in = '0;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err",  32'(bus.error), 0);
    chk("rst_bin",  32'(bus.bin_out), 0);
    #22 Reset_n = 1'b1;
    @(posedge Clock); #1;

    run_conv(24'h000000);
    run_conv(24'h999999);
    run_conv(24'h123456);
    run_conv(24'h12A456);
    run_conv(24'h000001);
    run_conv(24'hF00000);
    run_conv(24'h00000A);
    run_conv(24'h999999);

    for (int t = 0; t < 30; t++) begin
      v = '0;
      for (int k = 0; k < 6; k++) begin
        d = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 19) == 0) d = 4'($urandom_range(10, 15));
        v[4*k +: 4] = d;
      end
      run_conv(v);
    end

    // start re-pulsed with new data mid-conversion is ignored
    bus.bcd_in = 24'h000042; bus.start = 1'b1;
    @(posedge Clock); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    bus.bcd_in = 24'h000099; bus.start = 1'b1;
    @(posedge Clock); #1;
    bus.start = 1'b0;
    pulses = 0; cap = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge Clock); #1;
      if (bus.done) begin pulses++; cap = bus.bin_out; end
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_bin", 32'(cap), 32'h2A);

    // asynchronous reset mid-conversion
    bus.bcd_in = 24'h000500; bus.start = 1'b1;
    @(posedge Clock); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_err",  32'(bus.error), 0);
    chk("arst_bin",  32'(bus.bin_out), 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge Clock); #1;
      if (bus.done || bus.busy) pulses++;
    end
    chk("arst_quiet", pulses, 0);
    run_conv(24'h000007);

    // start held high: back-to-back conversions every 22 cycles
    bus.bcd_in = 24'h000010; bus.start = 1'b1;
    pulses = 0; last = -1;
    for (idx = 1; idx <= 80; idx++) begin
      @(posedge Clock); #1;
      if (bus.done) begin
        pulses++;
        chk("b2b_bin", 32'(bus.bin_out), 32'hA);
        if (last >= 0) chk("b2b_period", idx - last, 22);
        else chk("b2b_first", idx, 21);
        last = idx;
      end
    end
    chk("b2b_count", pulses, 3);
    bus.start = 1'b0;
    repeat (30) @(posedge Clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
